// File: rtl/excl_pkg.sv
// Shared types and limits for the exclusive-access sequencer.
// Included by excl_seq and its testbench.
package excl_pkg;

    localparam int STATE_W     = 3;
    localparam int TIMEOUT_DEF = 15;
    localparam int RETRY_MAX   = 3;
    localparam int WCNT_W      = 8;
    localparam int RCNT_W      = 2;
    localparam int HCNT_W      = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        ARM,
        WAIT,
        HOLD,
        CLEAR,
        DRAIN
    } state_t;

    function automatic logic [WCNT_W-1:0] sat_inc(
        input logic [WCNT_W-1:0] v,
        input logic [WCNT_W-1:0] max
    );
        return (v >= max) ? max : v + 1'b1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for asynchronous inputs.
// Synchronous active-low clear of every stage.
module bit_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/excl_seq.sv
// Two-client exclusive-access sequencer driving an external
// set/reset arbitration latch and granting the winner.
module excl_seq
    import excl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [3:0] hold_len,
    input  logic [1:0] x,
    output logic       sa,
    output logic       sb,
    output logic       lrst,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       busy,
    output logic       err
);

    localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [RCNT_W-1:0] RTY_LAST = RCNT_W'(RETRY_MAX);

    logic [1:0] xs;

    state_t state_q, state_d;
    logic   cap_a_q, cap_a_d;
    logic   cap_b_q, cap_b_d;
    logic   own_b_q, own_b_d;
    logic   err_q, err_d;
    logic   ccnt_q, ccnt_d;
    logic   sa_q, sa_d;
    logic   sb_q, sb_d;
    logic   lrst_q, lrst_d;
    logic   own_req, in_aw;

    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    bit_sync #(
        .WIDTH (2),
        .DEPTH (SYNC_STAGES)
    ) u_xsync (
        .clk (clk),
        .rst (rst),
        .d   (x),
        .q   (xs)
    );

    assign own_req = own_b_q ? req_b : req_a;

    always_comb begin
        state_d = state_q;
        cap_a_d = cap_a_q;
        cap_b_d = cap_b_q;
        own_b_d = own_b_q;
        err_d   = err_q;
        hcnt_d  = hcnt_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        ccnt_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                wcnt_d = '0;
                rcnt_d = '0;
                if (req_a || req_b) begin
                    cap_a_d = req_a;
                    cap_b_d = req_b;
                    state_d = ARM;
                end
            end
            ARM: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                unique case (xs)
                    2'b10: begin
                        own_b_d = 1'b0;
                        hcnt_d  = hold_len;
                        state_d = HOLD;
                    end
                    2'b01: begin
                        own_b_d = 1'b1;
                        hcnt_d  = hold_len;
                        state_d = HOLD;
                    end
                    2'b11: begin
                        err_d   = 1'b1;
                        state_d = CLEAR;
                    end
                    default: begin
                        if (wcnt_q >= TMO_LAST) begin
                            err_d   = 1'b1;
                            state_d = CLEAR;
                        end else begin
                            wcnt_d = sat_inc(wcnt_q, TMO_LAST);
                        end
                    end
                endcase
            end
            HOLD: begin
                // Owner withdrawal ends the hold immediately.
                if (!own_req || hcnt_q == '0) begin
                    state_d = CLEAR;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            CLEAR: begin
                if (ccnt_q) state_d = DRAIN;
                else        ccnt_d  = 1'b1;
            end
            DRAIN: begin
                if (xs == 2'b00) begin
                    state_d = IDLE;
                end else if (rcnt_q >= RTY_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch-side outputs are registered from the next state.
    assign in_aw  = (state_d == ARM) || (state_d == WAIT);
    assign sa_d   = in_aw && cap_a_d;
    assign sb_d   = in_aw && cap_b_d;
    assign lrst_d = (state_d == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cap_a_q <= 1'b0;
            cap_b_q <= 1'b0;
            own_b_q <= 1'b0;
            err_q   <= 1'b0;
            ccnt_q  <= 1'b0;
            hcnt_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            lrst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cap_a_q <= cap_a_d;
            cap_b_q <= cap_b_d;
            own_b_q <= own_b_d;
            err_q   <= err_d;
            ccnt_q  <= ccnt_d;
            hcnt_q  <= hcnt_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            lrst_q  <= lrst_d;
        end
    end

    assign sa    = sa_q;
    assign sb    = sb_q;
    assign lrst  = lrst_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);
    assign gnt_a = (state_q == HOLD) && !own_b_q && req_a;
    assign gnt_b = (state_q == HOLD) &&  own_b_q && req_b;

endmodule

// File: tb/tb_excl_seq.sv
// Transaction-level checker for excl_seq: each transaction is
// expanded into per-cycle stimulus and expected outputs.
module tb_excl_seq;

    localparam int TMO = 15;
    localparam int SS  = 2;
    localparam int NONE = 999;
    localparam int B_SA = 6, B_SB = 5, B_LR = 4;
    localparam int B_GA = 3, B_GB = 2, B_BZ = 1, B_ER = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b;
    logic [3:0] hold_len;
    logic [1:0] x;
    logic       sa, sb, lrst, gnt_a, gnt_b, busy, err;

    int checks = 0;
    int failures = 0;
    bit err_m = 1'b0;

    always #5 clk = ~clk;

    excl_seq #(
        .SYNC_STAGES (SS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .hold_len (hold_len),
        .x        (x),
        .sa       (sa),
        .sb       (sb),
        .lrst     (lrst),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .busy     (busy),
        .err      (err)
    );

    function automatic string nm(input int i);
        case (i)
            B_SA:    return "sa";
            B_SB:    return "sb";
            B_LR:    return "lrst";
            B_GA:    return "gnt_a";
            B_GB:    return "gnt_b";
            B_BZ:    return "busy";
            default: return "err";
        endcase
    endfunction

    task automatic cmp(input string ph, input int t, input logic [6:0] e);
        logic [6:0] got;
        got = {sa, sb, lrst, gnt_a, gnt_b, busy, err};
        for (int i = 0; i < 7; i++) begin
            checks++;
            assert (got[i] === e[i]) else begin
                failures++;
                $error("FAIL %s.%s cyc=%0d got=%b exp=%b",
                       ph, nm(i), t, got[i], e[i]);
            end
        end
    endtask

    task automatic drive(input logic a, input logic b,
                         input logic [3:0] h, input logic [1:0] xv);
        @(posedge clk);
        #1;
        req_a = a;
        req_b = b;
        hold_len = h;
        x = xv;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) begin
            drive(1'b0, 1'b0, 4'($urandom), 2'b00);
            cmp("idle", t, {6'b000000, err_m});
        end
    endtask

    // resp: 10 -> A wins, 01 -> B wins, 11 -> conflict, 00 -> timeout.
    // w: WAIT cycle at which the synced response appears.
    // hlf: forced hold_len (<0 random), drop: HOLD cycle owner drops req.
    // r: DRAIN cycles that still see the latch set (4 = retry exhaustion).
    task automatic run_txn(input bit ca, input bit cb, input logic [1:0] resp,
                           input int w, input int hlf, input int drop,
                           input int r);
        logic       ra [64];
        logic       rb [64];
        logic [3:0] hl [64];
        logic [1:0] xv [64];
        logic [6:0] ex [64];
        int c, e, n, len, rr, last, clr, t;
        bit ob;
        e = NONE;
        for (int i = 0; i < 64; i++) begin
            ra[i] = 1'($urandom);
            rb[i] = 1'($urandom);
            hl[i] = 4'($urandom);
            xv[i] = 2'b00;
            ex[i] = 7'b0000010;
        end
        ra[0] = ca;
        rb[0] = cb;
        ex[0] = '0;
        ex[1][B_SA] = ca;
        ex[1][B_SB] = cb;
        if (resp == 2'b00) begin
            r = 0;
            for (int i = 2; i < 2 + TMO; i++) begin
                ex[i][B_SA] = ca;
                ex[i][B_SB] = cb;
            end
            c = 2 + TMO;
            e = c;
        end else begin
            for (int i = 2; i <= 2 + w; i++) begin
                ex[i][B_SA] = ca;
                ex[i][B_SB] = cb;
            end
            if (resp == 2'b11) begin
                c = 3 + w;
                e = c;
            end else begin
                if (hlf >= 0) hl[2 + w] = 4'(hlf);
                ob = (resp == 2'b01);
                len = int'(hl[2 + w]) + 1;
                n = (drop >= 0 && drop < len) ? drop + 1 : len;
                for (int k = 0; k < n; k++) begin
                    t = 3 + w + k;
                    if (ob) rb[t] = (k != drop);
                    else    ra[t] = (k != drop);
                    ex[t][ob ? B_GB : B_GA] = (k != drop);
                end
                c = 3 + w + n;
            end
        end
        rr = (r > 3) ? 3 : r;
        last = c + 2 + 3 * rr;
        for (int i = 0; i <= rr; i++) begin
            ex[c + 3 * i][B_LR] = 1'b1;
            ex[c + 3 * i + 1][B_LR] = 1'b1;
        end
        clr = (r >= 4) ? c + 10 : c + 3 * r;
        if (resp != 2'b00)
            for (int i = w + 2 - SS; i < clr; i++) xv[i] = resp;
        for (int i = 0; i <= last; i++)
            ex[i][B_ER] = err_m || (i >= e);
        for (int i = 0; i <= last; i++) begin
            drive(ra[i], rb[i], hl[i], xv[i]);
            cmp("txn", i, ex[i]);
        end
        if (e != NONE || r >= 4) err_m = 1'b1;
    endtask

    initial begin
        int v, sel, w, dr, r;
        logic [1:0] resp;
        rst = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        hold_len = 4'd0;
        x = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset", 0, 7'b0010000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        cmp("reset", 1, 7'b0010000);
        idle(2);

        run_txn(1'b1, 1'b0, 2'b10, 1, 3, -1, 0);
        run_txn(1'b1, 1'b1, 2'b01, 2, 2, -1, 0);
        run_txn(1'b1, 1'b0, 2'b10, 0, 7, 1, 0);
        run_txn(1'b0, 1'b1, 2'b01, 3, 0, -1, 2);
        idle(1);
        run_txn(1'b0, 1'b1, 2'b11, 1, -1, -1, 0);
        run_txn(1'b1, 1'b0, 2'b10, 0, 1, -1, 0);
        run_txn(1'b1, 1'b0, 2'b00, 0, -1, -1, 0);
        run_txn(1'b1, 1'b1, 2'b10, 1, 2, -1, 4);

        // Reset in the middle of a grant to B.
        drive(1'b0, 1'b1, 4'd7, 2'b01);
        cmp("hrst", 0, {6'b000000, err_m});
        drive(1'b1, 1'b1, 4'd7, 2'b01);
        cmp("hrst", 1, {7'b0100010 | {6'b0, err_m}});
        drive(1'b0, 1'b1, 4'd7, 2'b01);
        cmp("hrst", 2, {7'b0100010 | {6'b0, err_m}});
        drive(1'b1, 1'b1, 4'd7, 2'b01);
        cmp("hrst", 3, {7'b0000110 | {6'b0, err_m}});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("hrst", 4, {7'b0000110 | {6'b0, err_m}});
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        x = 2'b00;
        @(negedge clk);
        err_m = 1'b0;
        cmp("hrst", 5, 7'b0010000);
        idle(1);
        run_txn(1'b0, 1'b1, 2'b01, 1, 2, -1, 0);

        for (int n = 0; n < 40; n++) begin
            v = $urandom_range(1, 3);
            sel = $urandom_range(0, 9);
            if (sel == 0)      resp = 2'b11;
            else if (sel == 1) resp = 2'b00;
            else if (v == 3)   resp = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            else               resp = v[1] ? 2'b10 : 2'b01;
            w = $urandom_range(0, 6);
            dr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            r = ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 4);
            run_txn(v[1], v[0], resp, w, -1, dr, r);
            idle($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/excl_seq.md
EXCL_SEQ -- requirements
Module: excl_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on x (range 2..3).
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before abort (range 1..255).
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 req_a  in  1  client A level request.
REQ-006 req_b  in  1  client B level request.
REQ-007 hold_len  in  4  grant hold length minus one, sampled at HOLD entry.
REQ-008 x  in  2  {ra,rb} from the two-party arbitration latch; asynchronous to clk.
REQ-009 sa  out  1  set request to latch side A, registered.
REQ-010 sb  out  1  set request to latch side B, registered.
REQ-011 lrst  out  1  latch clear, registered, active-high.
REQ-012 gnt_a  out  1  client A owns the resource.
REQ-013 gnt_b  out  1  client B owns the resource.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 err  out  1  sticky fault flag: conflict or timeout.

Function
REQ-016 x SHALL pass through SYNC_STAGES flops before use; xs denotes the synced value.
REQ-017 The FSM SHALL have states IDLE, ARM, WAIT, HOLD, CLEAR, DRAIN.
REQ-018 IDLE: if req_a|req_b, SHALL capture both request bits and go to ARM; otherwise stay, with all outputs 0 except err.
REQ-019 ARM: SHALL drive sa/sb from the captured bits for one cycle, then go to WAIT; the sa/sb edge occurs 1 cycle after the request is sampled.
REQ-020 WAIT: sa/sb SHALL stay held; xs=2'b10 -> HOLD as owner A; xs=2'b01 -> HOLD as owner B; xs=2'b11 -> set err, go to CLEAR; xs=2'b00 -> stay.
REQ-021 WAIT SHALL count cycles; on reaching TIMEOUT with xs=2'b00, SHALL set err and go to CLEAR.
REQ-022 HOLD: SHALL assert the owner's gnt for hold_len+1 cycles (hold_len=0 gives 1 cycle), then go to CLEAR; sa/sb SHALL deassert on HOLD entry.
REQ-023 HOLD: if the owner's req drops, HOLD SHALL end in that same cycle and go to CLEAR; the other client's req SHALL be ignored.
REQ-024 gnt_a and gnt_b SHALL never be high together; gnt SHALL be high only in HOLD.
REQ-025 CLEAR: SHALL assert lrst for exactly 2 cycles with sa=sb=0, then go to DRAIN.
REQ-026 DRAIN: lrst=0; xs=2'b00 -> IDLE; otherwise return to CLEAR, at most 3 retries, after which SHALL set err and go to IDLE.
REQ-027 Requests SHALL be sampled only in IDLE; changes during ARM/WAIT SHALL have no effect.
REQ-028 After DRAIN->IDLE, a pending request SHALL be served at the next cycle (back-to-back allowed).
REQ-029 err SHALL clear only under reset.
REQ-030 Counters SHALL be sized to their maximum value and SHALL saturate, never wrap.

Reset
REQ-031 rst=0 at a clock edge SHALL force: state IDLE, sync flops 0, counters 0, sa=sb=gnt_a=gnt_b=busy=err=0, lrst=1.
REQ-032 Reset asserted in any state, including mid-HOLD, SHALL take effect at the next edge with no completion of the current transaction.
REQ-033 After rst returns to 1, lrst SHALL go to 0 at the next edge.

Structure
REQ-034 The state enum, the state width and the TIMEOUT/retry limits SHALL live in the shared package excl_pkg.
REQ-035 The synchronizer SHALL be the sub-module bit_sync (parameterized width and depth), instantiated once for x.

Verification
REQ-036 req_a=1 only, latch returns x=10 -> sa pulses high from the cycle after the request; gnt_a is high for hold_len+1=4 cycles with hold_len=3; lrst is high 2 cycles; then IDLE.
REQ-037 req_a=req_b=1 in the same cycle, latch returns x=01 -> sa=sb=1 in ARM/WAIT; gnt_b only; gnt_a stays 0 throughout.
REQ-038 x forced to 11 in WAIT -> err=1 and lrst asserted; no gnt occurs; err remains 1 until rst=0.
REQ-039 x held at 00 with TIMEOUT=15 -> err rises after 15 WAIT cycles; CLEAR then IDLE follow.
REQ-040 rst=0 mid-HOLD -> next edge gives gnt=0, lrst=1, busy=0; after rst=1, a new req_b completes normally.
REQ-041 Owner req drops at the second HOLD cycle with hold_len=7 -> gnt falls that cycle and CLEAR follows immediately.
